// File: rtl/alu_result_display.sv
// alu_result_display: converts the 8-bit ALU result to BCD and flashes its significant digits on one 7-segment display
module alu_result_display #(
  parameter int HOLD_CYCLES  = 10_000_000,
  parameter int BLANK_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_sel,
  output logic       frame_start
);
  localparam int MX = HOLD_CYCLES > BLANK_CYCLES ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, CONV, SHOW, BLANK} state_t;
  state_t state;
  logic [7:0] snap;
  logic [11:0] bcd;
  logic [2:0] iter;
  logic [1:0] idx;
  logic [CW-1:0] cnt;
  logic [19:0] sh;
  logic [3:0] cur;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction
  assign sh = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0]), snap} << 1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      snap  <= '0;
      bcd   <= '0;
      iter  <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else
      case (state)
        IDLE: begin
          snap  <= result;
          bcd   <= '0;
          iter  <= '0;
          state <= CONV;
        end
        CONV: begin
          {bcd, snap} <= sh;
          iter <= iter + 3'd1;
          if (iter == 3'd7) begin
            state <= SHOW;
            idx   <= sh[19:16] != 4'd0 ? 2'd3 : sh[15:12] != 4'd0 ? 2'd2 : 2'd1;
            cnt   <= CW'(HOLD_CYCLES - 1);
          end
        end
        SHOW:
          if (cnt == '0) begin
            state <= BLANK;
            cnt   <= CW'(BLANK_CYCLES - 1);
          end else
            cnt <= cnt - CW'(1);
        BLANK:
          if (cnt != '0)
            cnt <= cnt - CW'(1);
          else if (idx == 2'd1)
            state <= IDLE;
          else begin
            idx   <= idx - 2'd1;
            state <= SHOW;
            cnt   <= CW'(HOLD_CYCLES - 1);
          end
      endcase
  always_comb begin
    cur         = idx == 2'd3 ? bcd[11:8] : idx == 2'd2 ? bcd[7:4] : bcd[3:0];
    seg         = state == SHOW ? dec(cur) : 7'h00;
    digit_sel   = state == SHOW ? idx : 2'd0;
    dp          = state == SHOW && idx == 2'd1;
    frame_start = state == IDLE && !rst;
  end
endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display: directed frame-by-frame checks of alu_result_display with short hold/blank times
module tb_alu_result_display;
  localparam int H = 4;
  localparam int B = 2;
  localparam int P = H + B;
  logic clk = 0, rst = 1;
  logic [7:0] result = 8'd255;
  logic [6:0] seg;
  logic dp, frame_start;
  logic [1:0] digit_sel;
  int total = 0, bad = 0;
  logic [6:0] g_seg [64];
  logic [1:0] g_sel [64];
  logic g_dp [64];
  logic g_fs [64];
  bit g_ok;
  logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  alu_result_display #(.HOLD_CYCLES(H), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .result(result), .seg(seg), .dp(dp),
    .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int ndig(input int v);
    return v >= 100 ? 3 : v >= 10 ? 2 : 1;
  endfunction

  function automatic int flen(input int v);
    return 9 + P * ndig(v);
  endfunction

  // Expected outputs c cycles after the frame_start sample of a frame capturing v.
  task automatic expect_at(input int v, input int c, output logic [6:0] es, output logic [1:0] esel,
                           output logic edp, output logic efs);
    int n, k, r, i, d;
    n = ndig(v);
    es = 7'h00; esel = 2'd0; edp = 1'b0;
    efs = (c == 0) || (c == 9 + P * n);
    if (c >= 9 && c < 9 + P * n) begin
      k = (c - 9) / P;
      r = (c - 9) % P;
      i = n - k;
      d = i == 3 ? v / 100 : i == 2 ? (v / 10) % 10 : v % 10;
      if (r < H) begin
        es = tbl[d]; esel = 2'(i); edp = (i == 1);
      end
    end
  endtask

  // Waits for frame_start, then records one full frame plus the next frame_start sample.
  task automatic grab(input int len, input int chg_at, input logic [7:0] chg_val);
    int n = 0;
    while (!frame_start && n < 200) begin
      step();
      n++;
    end
    g_ok = frame_start;
    for (int c = 0; c < len; c++) begin
      if (c > 0) step();
      g_seg[c] = seg; g_sel[c] = digit_sel; g_dp[c] = dp; g_fs[c] = frame_start;
      if (c == chg_at) result = chg_val;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({seg, dp, digit_sel, frame_start} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got seg=%h dp=%b sel=%0d fs=%b, want all 0", seg, dp, digit_sel, frame_start);
    end
    rst = 0;
  endtask

  task automatic test_frame(input int v, input string name);
    logic [6:0] es; logic [1:0] esel; logic edp, efs;
    result = 8'(v);
    grab(flen(v) + 1, -1, 8'd0);
    total++;
    if (!g_ok) begin
      bad++;
      $display("FAIL %s_timeout: frame_start not seen within 200 cycles", name);
    end
    for (int c = 0; c <= flen(v); c++) begin
      expect_at(v, c, es, esel, edp, efs);
      total++;
      if ({g_seg[c], g_sel[c], g_dp[c], g_fs[c]} !== {es, esel, edp, efs}) begin
        bad++;
        $display("FAIL %s v=%0d c=%0d: got seg=%h sel=%0d dp=%b fs=%b, want seg=%h sel=%0d dp=%b fs=%b",
                 name, v, c, g_seg[c], g_sel[c], g_dp[c], g_fs[c], es, esel, edp, efs);
      end
    end
  endtask

  task automatic test_change_mid_frame();
    logic [6:0] es; logic [1:0] esel; logic edp, efs;
    result = 8'd255;
    grab(flen(255) + 1, 10, 8'd42);
    for (int c = 0; c <= flen(255); c++) begin
      expect_at(255, c, es, esel, edp, efs);
      total++;
      if ({g_seg[c], g_sel[c], g_dp[c], g_fs[c]} !== {es, esel, edp, efs}) begin
        bad++;
        $display("FAIL change_old c=%0d: got seg=%h sel=%0d dp=%b, want seg=%h sel=%0d dp=%b",
                 c, g_seg[c], g_sel[c], g_dp[c], es, esel, edp);
      end
    end
    grab(flen(42) + 1, -1, 8'd0);
    for (int c = 0; c <= flen(42); c++) begin
      expect_at(42, c, es, esel, edp, efs);
      total++;
      if ({g_seg[c], g_sel[c], g_dp[c], g_fs[c]} !== {es, esel, edp, efs}) begin
        bad++;
        $display("FAIL change_new c=%0d: got seg=%h sel=%0d dp=%b, want seg=%h sel=%0d dp=%b",
                 c, g_seg[c], g_sel[c], g_dp[c], es, esel, edp);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    logic [6:0] es; logic [1:0] esel; logic edp, efs;
    result = 8'd255;
    grab(17, -1, 8'd0);
    total++;
    if (seg !== 7'h6D || digit_sel !== 2'd2) begin
      bad++;
      $display("FAIL pre_reset_tens: got seg=%h sel=%0d, want seg=6d sel=2", seg, digit_sel);
    end
    rst = 1;
    #1;
    total++;
    if ({seg, dp, digit_sel, frame_start} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset: got seg=%h dp=%b sel=%0d fs=%b, want all 0", seg, dp, digit_sel, frame_start);
    end
    step();
    rst = 0;
    #1;
    grab(flen(255) + 1, -1, 8'd0);
    for (int c = 0; c <= flen(255); c++) begin
      expect_at(255, c, es, esel, edp, efs);
      total++;
      if ({g_seg[c], g_sel[c], g_dp[c], g_fs[c]} !== {es, esel, edp, efs}) begin
        bad++;
        $display("FAIL after_reset c=%0d: got seg=%h sel=%0d dp=%b fs=%b, want seg=%h sel=%0d dp=%b fs=%b",
                 c, g_seg[c], g_sel[c], g_dp[c], g_fs[c], es, esel, edp, efs);
      end
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) test_frame(v, "sweep");
  endtask

  initial begin
    test_reset();
    test_frame(255, "frame_255");
    test_frame(7, "frame_7");
    test_frame(0, "frame_0");
    test_frame(105, "frame_105");
    test_change_mid_frame();
    test_reset_mid_show();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
